// File: rtl/ndn_pkg.sv
// Shared NDN router core types: PIT result codes, PIT state machine and request kinds.
package ndn_pkg;

  typedef enum logic [1:0] {
    PIT_ST_NEW = 2'd0,
    PIT_ST_AGG = 2'd1,
    PIT_ST_DUP = 2'd2,
    PIT_ST_REJ = 2'd3
  } pit_status_t;

  typedef enum logic [1:0] {
    PIT_IDLE = 2'd0,
    PIT_SCAN = 2'd1,
    PIT_RESP = 2'd2
  } pit_state_t;

  typedef enum logic {
    PIT_REQ_INT  = 1'b0,
    PIT_REQ_DATA = 1'b1
  } pit_req_t;

endpackage

// File: rtl/pit_entry_timer.sv
// Per-slot lifetime down-counter; reloads on load, saturates at zero, flags expiry.
module pit_entry_timer #(
  parameter int unsigned LIFETIME = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIFETIME + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_q;
    if (load) begin
      cnt_next = CNT_W'(LIFETIME);
    end else if (tick && (cnt_q != '0)) begin
      cnt_next = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      expired <= 1'b1;
    end else begin
      cnt_q   <= cnt_next;
      expired <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/pit_multiface_table.sv
// Multi-face Pending Interest Table: sequential slot scan for insert/aggregate/consume.
// Optional per-slot entry expiry is enabled by defining PIT_LIFETIME_EN.
module pit_multiface_table
  import ndn_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned PREFIX_W = 64,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned FACES    = 4,
  parameter int unsigned LIFETIME = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         int_valid,
  output logic                         int_ready,
  input  logic [PREFIX_W-1:0]          int_prefix,
  input  logic [LEN_W-1:0]             int_len,
  input  logic [$clog2(FACES)-1:0]     int_face,
  output logic                         int_done,
  output logic [1:0]                   int_status,
  output logic [$clog2(ENTRIES)-1:0]   int_slot,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [PREFIX_W-1:0]          data_prefix,
  input  logic [LEN_W-1:0]             data_len,
  output logic                         data_done,
  output logic                         data_hit,
  output logic [FACES-1:0]             data_faces,
  output logic [$clog2(ENTRIES+1)-1:0] occupancy,
  output logic                         expire_pulse
);

  localparam int unsigned FACE_W = $clog2(FACES);
  localparam int unsigned SLOT_W = $clog2(ENTRIES);
  localparam int unsigned OCC_W  = $clog2(ENTRIES + 1);

  pit_state_t state_q, state_next;

  logic [ENTRIES-1:0]  valid_q, valid_next;
  logic [PREFIX_W-1:0] prefix_q [ENTRIES];
  logic [LEN_W-1:0]    len_q    [ENTRIES];
  logic [FACES-1:0]    faces_q  [ENTRIES];

  pit_req_t            req_type_q;
  logic [PREFIX_W-1:0] req_prefix_q;
  logic [LEN_W-1:0]    req_len_q;
  logic [FACE_W-1:0]   req_face_q;

  logic [SLOT_W-1:0] scan_idx_q, hit_idx_q, free_idx_q;
  logic              hit_found_q, free_found_q;

  logic              accept, finish, last_scan, cur_hit, cur_free;
  logic              fin_hit, fin_free;
  logic [SLOT_W-1:0] fin_hit_idx, fin_free_idx;
  logic [FACES-1:0]  face_bit;
  logic              do_alloc, do_agg, do_consume, face_seen;
  logic [ENTRIES-1:0] expire_c;
  logic [OCC_W-1:0]  occ_next;

  // Slot under inspection this cycle, merged with earlier scan findings.
  assign last_scan    = (scan_idx_q == SLOT_W'(ENTRIES - 1));
  assign cur_hit      = valid_q[scan_idx_q] && (len_q[scan_idx_q] == req_len_q)
                        && (prefix_q[scan_idx_q] == req_prefix_q);
  assign cur_free     = !valid_q[scan_idx_q];
  assign fin_hit      = hit_found_q || cur_hit;
  assign fin_hit_idx  = hit_found_q ? hit_idx_q : scan_idx_q;
  assign fin_free     = free_found_q || cur_free;
  assign fin_free_idx = free_found_q ? free_idx_q : scan_idx_q;
  assign face_bit     = FACES'(1) << req_face_q;
  assign face_seen    = ((faces_q[fin_hit_idx] & face_bit) != '0);

  assign do_alloc   = finish && (req_type_q == PIT_REQ_INT) && !fin_hit && fin_free;
  assign do_agg     = finish && (req_type_q == PIT_REQ_INT) && fin_hit && !face_seen;
  assign do_consume = finish && (req_type_q == PIT_REQ_DATA) && fin_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIT_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      PIT_IDLE: begin
        if (data_valid || int_valid) begin
          accept     = 1'b1;
          state_next = PIT_SCAN;
        end
      end
      PIT_SCAN: begin
        if (last_scan) begin
          finish     = 1'b1;
          state_next = PIT_RESP;
        end
      end
      PIT_RESP: state_next = PIT_IDLE;
      default:  state_next = PIT_IDLE;
    endcase
  end

`ifdef PIT_LIFETIME_EN
  logic [ENTRIES-1:0] expired;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_timer
    logic load;
    assign load = (do_alloc && (fin_free_idx == SLOT_W'(i)))
                  || (do_agg && (fin_hit_idx == SLOT_W'(i)));
    pit_entry_timer #(
      .LIFETIME(LIFETIME)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .tick   (1'b1),
      .expired(expired[i])
    );
  end

  // Expiry only retires slots while no scan is in flight.
  assign expire_c = (state_q == PIT_IDLE) ? (valid_q & expired) : '0;
`else
  assign expire_c = '0;
`endif

  always_comb begin
    valid_next = valid_q & ~expire_c;
    if (do_alloc) begin
      valid_next[fin_free_idx] = 1'b1;
    end
    if (do_consume) begin
      valid_next[fin_hit_idx] = 1'b0;
    end
    occ_next = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_next;
      occupancy <= occ_next;
    end
  end

  // Slot payload; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      prefix_q[fin_free_idx] <= req_prefix_q;
      len_q[fin_free_idx]    <= req_len_q;
      faces_q[fin_free_idx]  <= face_bit;
    end
    if (do_agg) begin
      faces_q[fin_hit_idx] <= faces_q[fin_hit_idx] | face_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_type_q   <= PIT_REQ_INT;
      req_prefix_q <= '0;
      req_len_q    <= '0;
      req_face_q   <= '0;
      scan_idx_q   <= '0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      hit_found_q  <= 1'b0;
      free_found_q <= 1'b0;
    end else if (accept) begin
      req_type_q   <= data_valid ? PIT_REQ_DATA : PIT_REQ_INT;
      req_prefix_q <= data_valid ? data_prefix : int_prefix;
      req_len_q    <= data_valid ? data_len : int_len;
      req_face_q   <= int_face;
      scan_idx_q   <= '0;
      hit_found_q  <= 1'b0;
      free_found_q <= 1'b0;
    end else if (state_q == PIT_SCAN) begin
      scan_idx_q   <= scan_idx_q + SLOT_W'(1);
      hit_found_q  <= fin_hit;
      hit_idx_q    <= fin_hit_idx;
      free_found_q <= fin_free;
      free_idx_q   <= fin_free_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_ready    <= 1'b0;
      data_ready   <= 1'b0;
      int_done     <= 1'b0;
      int_status   <= '0;
      int_slot     <= '0;
      data_done    <= 1'b0;
      data_hit     <= 1'b0;
      data_faces   <= '0;
      expire_pulse <= 1'b0;
    end else begin
      int_ready    <= (state_next == PIT_IDLE);
      data_ready   <= (state_next == PIT_IDLE);
      int_done     <= 1'b0;
      data_done    <= 1'b0;
      expire_pulse <= (expire_c != '0);
      if (finish && (req_type_q == PIT_REQ_INT)) begin
        int_done <= 1'b1;
        if (fin_hit) begin
          int_status <= face_seen ? PIT_ST_DUP : PIT_ST_AGG;
          int_slot   <= fin_hit_idx;
        end else if (fin_free) begin
          int_status <= PIT_ST_NEW;
          int_slot   <= fin_free_idx;
        end else begin
          int_status <= PIT_ST_REJ;
          int_slot   <= '0;
        end
      end
      if (finish && (req_type_q == PIT_REQ_DATA)) begin
        data_done  <= 1'b1;
        data_hit   <= fin_hit;
        data_faces <= fin_hit ? faces_q[fin_hit_idx] : '0;
      end
    end
  end

endmodule

// File: doc/pit_multiface_table.md
# pit_multiface_table

Parametrised Pending Interest Table for the NDN router core. It replaces the single-face PIT/hash pair with one table of `ENTRIES` slots. Each slot holds a prefix, its length and a bitmask of requesting faces. Interests from `FACES` ingress faces are inserted, aggregated or rejected here. Returning data is matched against the table, yields the set of faces to forward to, and frees the slot. Optionally, stale entries expire after a fixed lifetime.

## Interface
Parameters:
- `ENTRIES`, 16: number of PIT slots (≥2).
- `PREFIX_W`, 64: prefix width in bits.
- `LEN_W`, 6: prefix-length field width.
- `FACES`, 4: number of faces; `FACE_W = $clog2(FACES)`.
- `LIFETIME`, 1024: entry lifetime in cycles; used only with `PIT_LIFETIME_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `int_valid` in 1: an interest request is presented.
- `int_ready` out 1: block can accept a request; high only in IDLE.
- `int_prefix` in PREFIX_W: interest prefix, zero-padded by the sender.
- `int_len` in LEN_W: interest prefix length.
- `int_face` in FACE_W: face the interest arrived on.
- `int_done` out 1: one-cycle pulse, interest result valid.
- `int_status` out 2: result code; 0 NEW, 1 AGGREGATED, 2 DUPLICATE, 3 REJECTED.
- `int_slot` out $clog2(ENTRIES): slot that was allocated or matched.
- `data_valid` in 1: a data packet lookup is presented.
- `data_ready` out 1: same as `int_ready`.
- `data_prefix` in PREFIX_W: data prefix.
- `data_len` in LEN_W: data prefix length.
- `data_done` out 1: one-cycle pulse, data lookup result valid.
- `data_hit` out 1: data matched a pending entry.
- `data_faces` out FACES: face bitmask of the matched entry, or 0 on a miss.
- `occupancy` out $clog2(ENTRIES+1): number of valid slots.
- `expire_pulse` out 1: high for one cycle when at least one entry expires.

## Operation
- State machine: IDLE → SCAN → RESP → IDLE.
- In IDLE, a request is accepted when valid && ready. If both request types are valid, data wins; the interest stays pending.
- The request's prefix, length, face and type are latched on accept.
- SCAN visits slot 0..ENTRIES-1, one slot per cycle.
  - A slot matches when it is valid, its len equals the request len and its prefix equals the request prefix.
  - The scan records the lowest matching index and the lowest free index.
- RESP, interest request:
  - Match, face bit clear → set the bit; status AGGREGATED.
  - Match, face bit already set → no table change; status DUPLICATE.
  - No match, free slot exists → write the entry with only the face bit set; status NEW. The caller forwards NEW interests to the FIB.
  - No match, table full → no table change; status REJECTED; `int_slot`=0.
- RESP, data request:
  - Match → `data_hit`=1, `data_faces`=entry mask, slot invalidated.
  - Miss → `data_hit`=0, `data_faces`=0.
- Result outputs hold until the next RESP; only the done pulses return to 0.
- `occupancy` is +1 on allocate, −1 on consume, −k on k expiries. It never exceeds ENTRIES.

## Timing
- Request accepted at edge T: SCAN spans T+1..T+ENTRIES. Done is high in cycle T+ENTRIES+1. Ready rises again in cycle T+ENTRIES+2.
- Throughput: one request per ENTRIES+2 cycles.
- Reset values: all slots invalid, state IDLE.
  - `int_ready`/`data_ready`=0 during reset, 1 in the first cycle after reset.
  - All other outputs 0.
- Reset during SCAN or RESP drops the in-flight request; no done pulse is generated.
- Table writes take effect at the RESP edge. A request accepted right after RESP sees the updated table.

## Configuration
- `PIT_LIFETIME_EN` defined:
  - Each slot has a down-counter. It loads LIFETIME on NEW and on AGGREGATED (refresh); DUPLICATE does not refresh.
  - Counters decrement every cycle and saturate at 0.
  - A valid slot whose counter is 0 is invalidated only while in IDLE, with `expire_pulse`=1 that cycle. Expiry is deferred while SCAN/RESP run.
  - If an expiry and an accept occur in the same IDLE cycle, the expiry applies first; the scan sees the slot as free.
- Not defined: no counters; entries live until consumed by data; `expire_pulse` tied to 0.

## Structure
- Shared package `ndn_pkg`: status codes `PIT_ST_NEW/AGG/DUP/REJ`, state enum `pit_state_t`, request-type enum.
- Sub-module `pit_entry_timer`: one per slot, instantiated only under `PIT_LIFETIME_EN`. It has load, tick and expired outputs.

## Test plan
All scenarios use ENTRIES=4, FACES=4 and LIFETIME=20 unless noted.
1. Interest 0xA5, len 8, face 1 on an empty table → `int_done` at T+5, status NEW, slot 0, occupancy 1.
2. Same prefix from face 3, then again from face 3 → AGGREGATED then DUPLICATE. Data 0xA5/8 → `data_hit`=1, `data_faces`=4'b1010, occupancy 0.
3. Five distinct interests → first four NEW in slots 0–3; fifth REJECTED. Data on slot 2's prefix, then a new interest → NEW in slot 2.
4. Data 0x77/8 on an empty table → `data_hit`=0, `data_faces`=0, occupancy unchanged. With data and interest valid in the same cycle, data is served first.
5. Macro on: one interest, then idle for 21 cycles → `expire_pulse` once, occupancy 0. A later data lookup on that prefix misses.
6. Assert `rst` in the middle of SCAN → no done pulse, occupancy 0, ready is 1 on the first cycle after reset.
